// File: rtl/address_sequencer.sv
// Address sequencer: emits SSID / hitInfo words for the hit-storage memories,
// either as a linear sweep (start/end/stride) or from a runtime-loaded table.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; table writable
// RUN    | emitting addresses; first cycle after start loads the first word
// DONE   | pass finished without loop; table writable, start re-arms
module address_sequencer #(
  parameter int SSIDBITS      = 8,
  parameter int NCOLS_HLM     = 16,
  parameter int TABLE_DEPTH   = 32,
  parameter int TBL_ADDR_BITS = $clog2(TABLE_DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     mode,
  input  logic                     loopEnable,
  input  logic [SSIDBITS-1:0]      linStart,
  input  logic [SSIDBITS-1:0]      linEnd,
  input  logic [SSIDBITS-1:0]      linStride,
  input  logic [TBL_ADDR_BITS:0]   tblLength,
  input  logic                     tblWrEn,
  input  logic [TBL_ADDR_BITS-1:0] tblWrAddr,
  input  logic [NCOLS_HLM-1:0]     tblWrData,
  input  logic                     storageReady,
  output logic [SSIDBITS-1:0]      SSID,
  output logic [NCOLS_HLM-1:0]     hitInfo,
  output logic                     newAddress,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [TBL_ADDR_BITS:0]   DEPTH_C   = (TBL_ADDR_BITS+1)'(TABLE_DEPTH);
  localparam logic [TBL_ADDR_BITS:0]   LEN_ONE   = (TBL_ADDR_BITS+1)'(1);
  localparam logic [TBL_ADDR_BITS-1:0] IDX_ONE   = TBL_ADDR_BITS'(1);
  localparam logic [SSIDBITS-1:0]      STRIDE_ONE = SSIDBITS'(1);

  state_e                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [NCOLS_HLM-1:0]     hit_q;
  logic [TBL_ADDR_BITS-1:0] idx_q, idx_d;
  logic                     mode_q, mode_d;
  logic                     loop_q, loop_d;
  logic [SSIDBITS-1:0]      lin_start_q, lin_start_d;
  logic [SSIDBITS-1:0]      lin_end_q, lin_end_d;
  logic [SSIDBITS-1:0]      stride_q, stride_d;
  logic [TBL_ADDR_BITS:0]   len_q, len_d;

  logic [NCOLS_HLM-1:0]     mem [TABLE_DEPTH];

  logic                     xfer;
  logic [SSIDBITS:0]        lin_sum;
  logic                     lin_last;
  logic                     tbl_last;
  logic                     pass_last;
  logic [TBL_ADDR_BITS-1:0] idx_next;
  logic                     tbl_load;
  logic                     lin_load;
  logic [TBL_ADDR_BITS-1:0] rd_idx;
  logic [SSIDBITS-1:0]      lin_addr;
  logic [NCOLS_HLM-1:0]     lin_word;

  // The output register doubles as the current linear address, so the
  // next-address sum is taken from its low bits. The extra sum bit catches
  // overflow so the sweep never wraps past 2^SSIDBITS.
  assign xfer      = valid_q & storageReady;
  assign lin_sum   = {1'b0, hit_q[SSIDBITS-1:0]} + {1'b0, stride_q};
  assign lin_last  = lin_sum[SSIDBITS] | (lin_sum[SSIDBITS-1:0] > lin_end_q);
  assign tbl_last  = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign pass_last = mode_q ? tbl_last : lin_last;
  assign idx_next  = idx_q + IDX_ONE;

  // Next-state, configuration latch and load-select for the output word.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    loop_d      = loop_q;
    lin_start_d = lin_start_q;
    lin_end_d   = lin_end_q;
    stride_d    = stride_q;
    len_d       = len_q;
    tbl_load    = 1'b0;
    lin_load    = 1'b0;
    rd_idx      = '0;
    lin_addr    = lin_start_q;

    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_RUN;
            valid_d     = 1'b0;
            idx_d       = '0;
            mode_d      = mode;
            loop_d      = loopEnable;
            lin_start_d = linStart;
            lin_end_d   = linEnd;
            stride_d    = (linStride == '0) ? STRIDE_ONE : linStride;
            len_d       = (tblLength > DEPTH_C) ? DEPTH_C : tblLength;
          end
        end
        S_RUN: begin
          if (!valid_q) begin
            // First cycle of the pass: fetch the first word (table read is
            // registered, so it appears together with newAddress).
            if (mode_q && (len_q == '0)) begin
              state_d = S_DONE;
            end else begin
              valid_d  = 1'b1;
              idx_d    = '0;
              rd_idx   = '0;
              tbl_load = mode_q;
              lin_load = ~mode_q;
              lin_addr = lin_start_q;
            end
          end else if (xfer) begin
            if (pass_last) begin
              if (loop_q) begin
                idx_d    = '0;
                rd_idx   = '0;
                tbl_load = mode_q;
                lin_load = ~mode_q;
                lin_addr = lin_start_q;
              end else begin
                state_d = S_DONE;
                valid_d = 1'b0;
              end
            end else begin
              idx_d    = idx_next;
              rd_idx   = idx_next;
              tbl_load = mode_q;
              lin_load = ~mode_q;
              lin_addr = lin_sum[SSIDBITS-1:0];
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Linear addresses are presented zero-extended on hitInfo.
  always_comb begin
    lin_word                 = '0;
    lin_word[SSIDBITS-1:0]   = lin_addr;
  end

  // Control and configuration registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      loop_q      <= 1'b0;
      lin_start_q <= '0;
      lin_end_q   <= '0;
      stride_q    <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      loop_q      <= loop_d;
      lin_start_q <= lin_start_d;
      lin_end_q   <= lin_end_d;
      stride_q    <= stride_d;
      len_q       <= len_d;
    end
  end

  // Output word: registered table read or next linear address; holds on stall.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hit_q <= '0;
    end else if (tbl_load) begin
      hit_q <= mem[rd_idx];
    end else if (lin_load) begin
      hit_q <= lin_word;
    end
  end

  // Table storage; writes are locked out while a pass is running.
  always_ff @(posedge clock) begin
    if (tblWrEn && (state_q != S_RUN)) begin
      mem[tblWrAddr] <= tblWrData;
    end
  end

  assign SSID       = hit_q[SSIDBITS-1:0];
  assign hitInfo    = hit_q;
  assign newAddress = valid_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_address_sequencer.sv
// Directed testbench for address_sequencer (default parameters).
module tb_address_sequencer;

  logic        clock;
  logic        resetN;
  logic        start;
  logic        abort;
  logic        mode;
  logic        loopEnable;
  logic [7:0]  linStart;
  logic [7:0]  linEnd;
  logic [7:0]  linStride;
  logic [5:0]  tblLength;
  logic        tblWrEn;
  logic [4:0]  tblWrAddr;
  logic [15:0] tblWrData;
  logic        storageReady;
  logic [7:0]  SSID;
  logic [15:0] hitInfo;
  logic        newAddress;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_hit [64];
  int          n_got;
  int          hold_err;
  bit          timed_out;

  address_sequencer dut (
    .clock(clock), .resetN(resetN), .start(start), .abort(abort),
    .mode(mode), .loopEnable(loopEnable), .linStart(linStart),
    .linEnd(linEnd), .linStride(linStride), .tblLength(tblLength),
    .tblWrEn(tblWrEn), .tblWrAddr(tblWrAddr), .tblWrData(tblWrData),
    .storageReady(storageReady), .SSID(SSID), .hitInfo(hitInfo),
    .newAddress(newAddress), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] clamp_entry(input int i);
    return 16'(((i & 255) << 8) | ((i * 7 + 1) & 255));
  endfunction

  task automatic tbl_write(input logic [4:0] a, input logic [15:0] d);
    tblWrEn = 1'b1; tblWrAddr = a; tblWrData = d;
    tick;
    tblWrEn = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic lp, input logic [7:0] ls,
                          input logic [7:0] le, input logic [7:0] st, input logic [5:0] len);
    mode = m; loopEnable = lp; linStart = ls; linEnd = le; linStride = st; tblLength = len;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Records every transfer until done; ready_mode 0 = always ready, 1 = toggling.
  task automatic collect(input int ready_mode, input int budget);
    logic [15:0] prev;
    bit stalled;
    prev = '0; stalled = 0;
    n_got = 0; hold_err = 0; timed_out = 1;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        timed_out = 0;
        break;
      end
      storageReady = (ready_mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (stalled && newAddress && (hitInfo !== prev)) hold_err++;
      if (newAddress && storageReady) begin
        if (n_got < 64) got_hit[n_got] = hitInfo;
        n_got++;
        stalled = 0;
      end else begin
        stalled = newAddress;
        prev = hitInfo;
      end
      tick;
    end
    storageReady = 1'b1;
  endtask

  task automatic test_reset;
    resetN = 1'b0; start = 0; abort = 0; mode = 0; loopEnable = 0;
    linStart = 0; linEnd = 0; linStride = 0; tblLength = 0;
    tblWrEn = 0; tblWrAddr = 0; tblWrData = 0; storageReady = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (SSID !== 8'h00) begin failures++; $display("FAIL rst_ssid got=%0h exp=0", SSID); end
    checks++; if (hitInfo !== 16'h0) begin failures++; $display("FAIL rst_hit got=%0h exp=0", hitInfo); end
    checks++; if (newAddress !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", newAddress); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%0b%0b exp=00", busy, done); end
    resetN = 1'b1;
    tick;
    checks++; if (busy !== 1'b0 || newAddress !== 1'b0) begin failures++; $display("FAIL idle_after_rst got=%0b%0b exp=00", busy, newAddress); end
  endtask

  task automatic test_linear;
    storageReady = 1'b1;
    do_start(1'b0, 1'b0, 8'd3, 8'd12, 8'd3, 6'd0);
    checks++; if (newAddress !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL lin_latency got=v%0b b%0b exp=v0 b1", newAddress, busy); end
    tick;
    checks++; if (newAddress !== 1'b1 || hitInfo !== 16'd3) begin failures++; $display("FAIL lin_first got=v%0b %0h exp=v1 3", newAddress, hitInfo); end
    for (int i = 1; i < 4; i++) begin
      tick;
      checks++;
      if (newAddress !== 1'b1 || SSID !== 8'(3 + 3 * i)) begin
        failures++; $display("FAIL lin_seq%0d got=v%0b %0d exp=v1 %0d", i, newAddress, SSID, 3 + 3 * i);
      end
    end
    tick;
    checks++; if (done !== 1'b1 || newAddress !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lin_done got=d%0b v%0b b%0b exp=d1 v0 b0", done, newAddress, busy); end
  endtask

  task automatic test_linear_boundary;
    do_start(1'b0, 1'b0, 8'd250, 8'd255, 8'd4, 6'd0);
    collect(0, 20);
    checks++; if (timed_out || n_got !== 2) begin failures++; $display("FAIL lin_nowrap_count got=%0d to=%0b exp=2", n_got, timed_out); end
    checks++; if (got_hit[0] !== 16'd250 || got_hit[1] !== 16'd254) begin failures++; $display("FAIL lin_nowrap_vals got=%0d,%0d exp=250,254", got_hit[0], got_hit[1]); end
    do_start(1'b0, 1'b0, 8'd5, 8'd7, 8'd0, 6'd0);
    collect(0, 20);
    checks++; if (timed_out || n_got !== 3) begin failures++; $display("FAIL lin_stride0_count got=%0d exp=3", n_got); end
    checks++; if (got_hit[0] !== 16'd5 || got_hit[1] !== 16'd6 || got_hit[2] !== 16'd7) begin failures++; $display("FAIL lin_stride0_vals got=%0h,%0h,%0h exp=5,6,7", got_hit[0], got_hit[1], got_hit[2]); end
    do_start(1'b0, 1'b0, 8'd20, 8'd10, 8'd1, 6'd0);
    collect(0, 20);
    checks++; if (timed_out || n_got !== 1 || got_hit[0] !== 16'd20) begin failures++; $display("FAIL lin_start_gt_end got=n%0d %0d exp=n1 20", n_got, got_hit[0]); end
  endtask

  task automatic test_table_stall;
    tbl_write(5'd0, 16'h1203);
    tbl_write(5'd1, 16'h347C);
    tbl_write(5'd2, 16'h5684);
    tbl_write(5'd3, 16'h78F0);
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd4);
    collect(1, 40);
    checks++; if (timed_out || n_got !== 4) begin failures++; $display("FAIL tbl_count got=%0d to=%0b exp=4", n_got, timed_out); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL tbl_hold got=%0d exp=0", hold_err); end
    checks++; if (got_hit[0] !== 16'h1203 || got_hit[1] !== 16'h347C) begin failures++; $display("FAIL tbl_first got=%0h,%0h exp=1203,347c", got_hit[0], got_hit[1]); end
    checks++; if (got_hit[2] !== 16'h5684 || got_hit[3] !== 16'h78F0) begin failures++; $display("FAIL tbl_last got=%0h,%0h exp=5684,78f0", got_hit[2], got_hit[3]); end
  endtask

  task automatic test_write_in_run;
    storageReady = 1'b1;
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd4);
    tblWrEn = 1'b1; tblWrAddr = 5'd1; tblWrData = 16'hFFFF;
    tick;
    tblWrEn = 1'b0;
    collect(0, 20);
    checks++; if (n_got !== 4 || got_hit[1] !== 16'h347C) begin failures++; $display("FAIL wr_run_pass1 got=n%0d %0h exp=n4 347c", n_got, got_hit[1]); end
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd4);
    collect(0, 20);
    checks++; if (n_got !== 4 || got_hit[1] !== 16'h347C) begin failures++; $display("FAIL wr_run_pass2 got=n%0d %0h exp=n4 347c", n_got, got_hit[1]); end
  endtask

  task automatic test_write_with_start;
    tblWrEn = 1'b1; tblWrAddr = 5'd0; tblWrData = 16'h0055;
    mode = 1'b1; loopEnable = 1'b0; tblLength = 6'd4;
    start = 1'b1;
    tick;
    start = 1'b0; tblWrEn = 1'b0;
    collect(0, 20);
    checks++; if (n_got !== 4 || got_hit[0] !== 16'h0055) begin failures++; $display("FAIL wr_start got=n%0d %0h exp=n4 55", n_got, got_hit[0]); end
  endtask

  task automatic test_loop_abort;
    tbl_write(5'd0, 16'h0011);
    tbl_write(5'd1, 16'h0022);
    storageReady = 1'b1;
    do_start(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 6'd2);
    tick;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (newAddress !== 1'b1 || SSID !== (((i % 2) == 0) ? 8'h11 : 8'h22)) begin
        failures++; $display("FAIL loop_seq%0d got=v%0b %0h exp=v1 %0h", i, newAddress, SSID, ((i % 2) == 0) ? 8'h11 : 8'h22);
      end
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (newAddress !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle got=v%0b b%0b d%0b exp=000", newAddress, busy, done); end
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_prio got=%0b exp=0", busy); end
  endtask

  task automatic test_zero_length;
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd0);
    checks++; if (busy !== 1'b1 || newAddress !== 1'b0) begin failures++; $display("FAIL zero_run got=b%0b v%0b exp=b1 v0", busy, newAddress); end
    tick;
    checks++; if (done !== 1'b1 || newAddress !== 1'b0) begin failures++; $display("FAIL zero_done got=d%0b v%0b exp=d1 v0", done, newAddress); end
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 32; i++) tbl_write(5'(i), clamp_entry(i));
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd40);
    collect(0, 100);
    checks++; if (timed_out || n_got !== 32) begin failures++; $display("FAIL clamp_count got=%0d to=%0b exp=32", n_got, timed_out); end
    checks++; if (got_hit[0] !== clamp_entry(0) || got_hit[31] !== clamp_entry(31)) begin failures++; $display("FAIL clamp_ends got=%0h,%0h exp=%0h,%0h", got_hit[0], got_hit[31], clamp_entry(0), clamp_entry(31)); end
  endtask

  task automatic test_reset_mid_run;
    storageReady = 1'b1;
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd4);
    tick;
    tick;
    #2 resetN = 1'b0;
    #1;
    checks++; if (SSID !== 8'h0 || hitInfo !== 16'h0 || newAddress !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid got=%0h %0h v%0b b%0b exp=0 0 v0 b0", SSID, hitInfo, newAddress, busy); end
    @(posedge clock);
    #1 resetN = 1'b1;
    do_start(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 6'd4);
    tick;
    checks++; if (newAddress !== 1'b1 || hitInfo !== clamp_entry(0)) begin failures++; $display("FAIL rst_replay got=v%0b %0h exp=v1 %0h", newAddress, hitInfo, clamp_entry(0)); end
    collect(0, 20);
    checks++; if (n_got !== 4 || got_hit[3] !== clamp_entry(3)) begin failures++; $display("FAIL rst_replay_pass got=n%0d %0h exp=n4 %0h", n_got, got_hit[3], clamp_entry(3)); end
  endtask

  initial begin
    test_reset;
    test_linear;
    test_linear_boundary;
    test_table_stall;
    test_write_in_run;
    test_write_with_start;
    test_loop_abort;
    test_zero_length;
    test_clamp;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
- Parametrised SSID address generator feeding the hit-storage memories (HNM/HCM); successor to the fixed-list address counter.
- Two modes: linear sweep (start/end/stride) and a runtime-loadable table of up to TABLE_DEPTH entries.
- Full valid/ready handshake with back-pressure, optional continuous looping, and abort.
- Every programmed SSID is emitted exactly once per pass, first and last included.

Parameters:
SSIDBITS, 8, width of SSID
NCOLS_HLM, 16, width of hitInfo word; must be >= SSIDBITS
TABLE_DEPTH, 32, number of table entries
TBL_ADDR_BITS, $clog2(TABLE_DEPTH), table index width

Ports:
clock  in  1  system clock, all logic on rising edge
resetN  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a pass sequence; honoured only in IDLE or DONE
abort  in  1  return to IDLE; honoured in any state
mode  in  1  0 = linear, 1 = table; sampled with start
loopEnable  in  1  1 = wrap to first address after last; sampled with start
linStart  in  SSIDBITS  first SSID in linear mode; sampled with start
linEnd  in  SSIDBITS  inclusive upper bound in linear mode; sampled with start
linStride  in  SSIDBITS  increment in linear mode; 0 treated as 1; sampled with start
tblLength  in  TBL_ADDR_BITS+1  number of valid table entries, 0..TABLE_DEPTH; sampled with start
tblWrEn  in  1  table write strobe; honoured only when not RUN
tblWrAddr  in  TBL_ADDR_BITS  table write index
tblWrData  in  NCOLS_HLM  table entry; bits [SSIDBITS-1:0] are the SSID
storageReady  in  1  downstream accepts current address this cycle
SSID  out  SSIDBITS  current address
hitInfo  out  NCOLS_HLM  current hit word
newAddress  out  1  SSID/hitInfo valid
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset (async, resetN low):
  - state = IDLE; SSID = 0; hitInfo = 0; newAddress = 0; busy = 0; done = 0.
  - All internal counters are 0.
  - Table contents are not reset.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: last transfer with loopEnable = 0 -> DONE.
  - DONE: start -> RUN.
  - Any state: abort -> IDLE on the next edge. abort has priority over start and over a transfer in the same cycle.
  - start in RUN is ignored.
- Start and handshake:
  - On start, configuration inputs are latched. If start is sampled at edge N, newAddress is 1 after edge N+1, carrying the first address.
  - Transfer happens when newAddress and storageReady are both 1 at an edge.
  - SSID and hitInfo hold stable while newAddress = 1 and storageReady = 0.
  - With storageReady held at 1, there is one transfer per cycle with no bubbles.
  - newAddress drops to 0 on the edge of the final transfer (no loop), and on abort.
- Linear mode:
  - Sequence is linStart, linStart+s, ..., last value <= linEnd, where s = max(linStride, 1).
  - The next-address sum is computed in SSIDBITS+1 bits; carry-out or sum > linEnd ends the pass. The address never wraps modulo 2^SSIDBITS.
  - linStart > linEnd: a single address, linStart, is emitted.
  - hitInfo = SSID zero-extended to NCOLS_HLM.
- Table mode:
  - Entries 0..tblLength-1 are emitted in index order.
  - SSID = entry[SSIDBITS-1:0]; hitInfo = full entry.
  - tblLength = 0: RUN lasts one cycle, no address is emitted, then DONE.
  - tblLength > TABLE_DEPTH is clamped to TABLE_DEPTH.
  - Table reads are registered; that latency is absorbed by the one-cycle start latency and a one-entry lookahead, so there are no bubbles.
- Loop: with loopEnable = 1, the transfer of the last address is followed directly by the first address. Running continues until abort.
- Table writes:
  - Written on the edge when tblWrEn = 1 and state != RUN. tblWrEn during RUN is dropped.
  - A write and a start in the same cycle: the write lands first, and the pass uses the new data.

Test Plan:
- Linear, linStart=3, linEnd=12, linStride=3, storageReady=1 -> SSIDs 3, 6, 9, 12 on four consecutive cycles; done=1 on the cycle after the 12 transfer.
- Table with 4 entries {0x03, 0x7C, 0x84, 0xF0}, tblLength=4, storageReady toggling 1, 0 -> each SSID held across stalled cycles; exactly 4 transfers, first 0x03 and last 0xF0.
- Linear, linStart=250, linEnd=255, linStride=4, SSIDBITS=8 -> emits 250 and 254 only, with no wrap to 2.
- loopEnable=1, table length 2 {0x11, 0x22} -> 0x11, 0x22, 0x11, 0x22, ...; abort asserted -> newAddress=0 and state IDLE after the next edge.
- Edge cases: tblLength=0 -> no newAddress pulse, done=1 two edges after start. resetN pulled low mid-RUN -> outputs immediately 0, and the next start replays from the first entry.
- tblWrEn in RUN -> table unchanged, verified by a second pass.
